// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: FWFT FIFO of retired-instruction trace entries; clock/reset(async low), en/clear control, wb_* retire inputs, rd_* head outputs, count, sticky overflow
module cpu_trace_buffer #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16,
  parameter int FILTER  = 1,
  parameter int WRAP    = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clear,
  input  logic                     wb_valid,
  input  logic                     wb_reg_write,
  input  logic [REG_W-1:0]         wb_num_write,
  input  logic [DATA_W-1:0]        wb_data_write,
  input  logic [DATA_W-1:0]        wb_pc,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DATA_W-1:0]        rd_pc,
  output logic [REG_W-1:0]         rd_num,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_we,
  output logic [STAMP_W-1:0]       rd_stamp,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] pc_mem [DEPTH];
  logic [REG_W-1:0] num_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic we_mem [DEPTH];
  logic [STAMP_W-1:0] stamp_mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [STAMP_W-1:0] stamp;
  logic cap, full, pop, wr, adv;
  always_comb begin
    cap = en && wb_valid && (FILTER == 0 || wb_reg_write);
    full = count == (AW+1)'(DEPTH);
    pop = rd_valid && rd_ready;
    wr = cap && (!full || pop || WRAP != 0);
    adv = pop || (cap && full && WRAP != 0);
  end
  assign rd_valid = count != '0;
  assign rd_pc = pc_mem[head];
  assign rd_num = num_mem[head];
  assign rd_data = data_mem[head];
  assign rd_we = we_mem[head];
  assign rd_stamp = stamp_mem[head];
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      stamp <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      stamp <= '0;
      overflow <= 1'b0;
    end else begin
      stamp <= stamp + 1'b1;
      if (wr) tail <= tail + 1'b1;
      if (adv) head <= head + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(adv);
      if (cap && full && !pop) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (wr && !clear) begin
      pc_mem[tail] <= wb_pc;
      num_mem[tail] <= wb_num_write;
      data_mem[tail] <= wb_data_write;
      we_mem[tail] <= wb_reg_write;
      stamp_mem[tail] <= stamp;
    end
  end
endmodule

// File: doc/cpu_trace_buffer.md
CPU_TRACE_BUFFER -- requirements
Module: cpu_trace_buffer

Interface
Parameters (name, default, meaning):
REQ-001 SHALL have parameter DATA_W, 32, width of the writeback data and PC fields.
REQ-002 SHALL have parameter REG_W, 5, width of the register-number field.
REQ-003 SHALL have parameter DEPTH, 16, number of trace entries; a power of two, at least 2.
REQ-004 SHALL have parameter STAMP_W, 16, width of the cycle stamp.
REQ-005 SHALL have parameter FILTER, 1, capture mode: 1 = capture only register-writing retirements; 0 = capture every retirement.
REQ-006 SHALL have parameter WRAP, 0, full-buffer policy: 0 = drop the new entry; 1 = overwrite the oldest entry.

Ports (name, direction, width, meaning):
REQ-007 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port en, input, 1, capture enable.
REQ-010 SHALL have port clear, input, 1, synchronous flush.
REQ-011 SHALL have port wb_valid, input, 1, an instruction retires this cycle.
REQ-012 SHALL have port wb_reg_write, input, 1, the retiring instruction writes the GPR file.
REQ-013 SHALL have port wb_num_write, input, REG_W, destination register number.
REQ-014 SHALL have port wb_data_write, input, DATA_W, writeback data.
REQ-015 SHALL have port wb_pc, input, DATA_W, PC of the retiring instruction.
REQ-016 SHALL have port rd_ready, input, 1, consumer pops the head entry.
REQ-017 SHALL have port rd_valid, output, 1, the head entry is available.
REQ-018 SHALL have ports rd_pc (DATA_W), rd_num (REG_W), rd_data (DATA_W), rd_we (1) and rd_stamp (STAMP_W), all outputs, carrying the fields of the head entry.
REQ-019 SHALL have port count, output, $clog2(DEPTH)+1, number of stored entries.
REQ-020 SHALL have port overflow, output, 1, sticky flag: an entry was lost.

Function
REQ-021 Capture condition SHALL be en && wb_valid && (FILTER==0 || wb_reg_write); a captured entry stores {wb_pc, wb_num_write, wb_data_write, wb_reg_write, stamp}.
REQ-022 stamp SHALL be a free-running STAMP_W counter, +1 every clock, wrapping from all-ones to 0; the value stored is the pre-increment value at the capture edge.
REQ-023 Storage SHALL be a circular FIFO with head and tail pointers that wrap at DEPTH; count SHALL range from 0 to DEPTH.
REQ-024 Reads SHALL be first-word-fall-through: rd_valid = (count != 0), and the rd_* fields SHALL be driven combinationally from the head entry.
REQ-025 An entry captured at edge N SHALL be visible on rd_* after edge N (latency 1).
REQ-026 A pop SHALL occur when rd_valid && rd_ready; rd_ready while empty SHALL be ignored.
REQ-027 Capture and pop in the same cycle, with count in 1..DEPTH-1, SHALL leave count unchanged.
REQ-028 Full with WRAP=0 and capture without pop: the entry SHALL be dropped, overflow SHALL be set, and count SHALL stay at DEPTH.
REQ-029 Full with WRAP=1 and capture without pop: the head entry SHALL be overwritten and the head SHALL advance, overflow SHALL be set, and count SHALL stay at DEPTH.
REQ-030 Full with capture and pop together SHALL be accepted in either mode with no overflow.
REQ-031 Empty with capture and pop together: the pop SHALL be ignored and the entry stored, giving count = 1.
REQ-032 clear SHALL empty the FIFO, zero the stamp counter and clear overflow; clear SHALL take priority over a same-cycle capture or pop, and both SHALL be discarded.
REQ-033 overflow SHALL be cleared only by clear or reset.
REQ-034 When rd_valid = 0, the rd_* fields SHALL be don't-care; the bench SHALL NOT check them.

Reset
REQ-035 reset low SHALL immediately force count = 0, rd_valid = 0, overflow = 0, both pointers to 0 and stamp to 0, regardless of clock.
REQ-036 Storage array contents SHALL NOT require reset.
REQ-037 Reset asserted mid-operation SHALL discard all entries; capture SHALL resume on the first rising edge after reset deasserts.

Verification (bench: DEPTH=4, STAMP_W=8, FILTER=1, WRAP=0 unless stated; the bench also covers the other FILTER and WRAP values as stated per scenario)
REQ-038 Pulse reset low for 2 ns mid-cycle, then capture pc=0x0, num=3, data=0x3 with wb_reg_write=1 on the first edge -> count=1, rd_valid=1, rd_stamp=0.
REQ-039 Five retirements with wb_reg_write=1,0,1,1,1 at pc 0x0,0x4,0x8,0xC,0x10, rd_ready=0 -> count=4; pops yield pc 0x0,0x8,0xC,0x10 in that order; overflow=0.
REQ-040 Fill 4 entries, then one more capture with WRAP=0 -> count=4, overflow=1, head pc unchanged; repeat with WRAP=1 -> head holds the second capture and the tail holds the fifth.
REQ-041 Full buffer with capture and rd_ready=1 in the same cycle -> count stays 4, overflow=0, the new entry is at the tail; empty buffer with capture and rd_ready=1 -> count=1.
REQ-042 clear asserted together with a capture on a buffer holding 3 entries with overflow=1 -> next cycle count=0, overflow=0, rd_valid=0, stamp=0.
REQ-043 Run 260 idle cycles, then capture -> rd_stamp=260 mod 256=4, confirming stamp wrap.
